// File: rtl/serial_adder16.sv
// Nibble-serial adder sequencer: drives one 4-bit ripple cell for WIDTH/4 cycles, LSB nibble first.
// Trades latency for area; accepts operands and returns the result over valid/ready handshakes.

module fulladder4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CI,
    output logic [3:0] SUM,
    output logic       CO
);

    assign {CO, SUM} = {1'b0, A} + {1'b0, B} + {4'b0000, CI};

endmodule

module serial_adder16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned CNTW = $clog2(NIB);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_q;
    logic             carry_q, a_msb, b_msb;
    logic [CNTW-1:0]  cnt;
    logic [3:0]       nib_sum;
    logic             nib_co;
    logic             last_nib;

    fulladder4 u_fa (
        .A   (a_sh[3:0]),
        .B   (b_sh[3:0]),
        .CI  (carry_q),
        .SUM (nib_sum),
        .CO  (nib_co)
    );

    assign last_nib = (cnt == CNTW'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            StIdle:  if (in_valid)  state_next = StRun;
            StRun:   if (last_nib)  state_next = StDone;
            StDone:  if (out_ready) state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        a_msb   <= a[WIDTH-1];
                        b_msb   <= b[WIDTH-1];
                        cnt     <= '0;
                        sum_q   <= '0;
                    end
                end
                StRun: begin
                    // Each new nibble enters at the top; after NIB shifts nibble 0 sits at the bottom.
                    sum_q   <= {nib_sum, sum_q[WIDTH-1:4]};
                    carry_q <= nib_co;
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == StIdle);
    assign out_valid = (state == StDone);
    assign busy      = (state == StRun);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign ovf       = (a_msb == b_msb) && (sum_q[WIDTH-1] != a_msb);

endmodule

// File: tb/tb_serial_adder16.sv
// Directed bench for serial_adder16: scoreboard of expected results, immediate-assertion checks.

module tb_serial_adder16;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, cin;
    logic        in_ready, out_valid, cout, ovf, busy;
    logic [15:0] a, b, sum;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t sb[$];
    res_t held;

    serial_adder16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic res_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
        logic [16:0] full;
        res_t        r;
        full   = {1'b0, ta} + {1'b0, tb_} + {16'b0, tc};
        r.sum  = full[15:0];
        r.cout = full[16];
        r.ovf  = (ta[15] == tb_[15]) && (full[15] != ta[15]);
        return r;
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge after acceptance.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input bit expect_result);
        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = 1'b1;
        check("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        if (expect_result) sb.push_back(model(ta, tb_, tc));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output res_t e);
        int cyc = 0;
        e = '0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            check("busy_in_run", busy, 1);
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, 4);
        check("out_valid", out_valid, 1);
        check("scoreboard_depth", sb.size(), 1);
        if (sb.size() > 0) e = sb.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
        check("ovf", ovf, e.ovf);
        check("in_ready_in_done", in_ready, 0);
        check("busy_in_done", busy, 0);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_handshake", in_ready, 1);
        check("out_valid_after_handshake", out_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sum"}, sum, 16'h0000);
        check({tag, "_cout"}, cout, 0);
        check({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Asynchronous reset mid-cycle, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h1234, 16'h4321, 1'b0, 1);
        wait_result(held);
        consume();
        check("sum_hold_idle", sum, 16'h5555);

        issue(16'hFFFF, 16'h0001, 1'b0, 1);
        wait_result(held);
        consume();

        issue(16'h7FFF, 16'h0000, 1'b1, 1);
        wait_result(held);
        consume();

        issue(16'h8000, 16'h8000, 1'b0, 1);
        wait_result(held);
        consume();

        // Backpressure: new operands waiting while the result is held.
        issue(16'h1111, 16'h2222, 1'b0, 1);
        wait_result(held);
        a        = 16'h0F00;
        b        = 16'h0100;
        cin      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_sum_stable", sum, held.sum);
            check("bp_cout_stable", cout, held.cout);
            check("bp_ovf_stable", ovf, held.ovf);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        consume();
        issue(16'h0F00, 16'h0100, 1'b1, 1);
        wait_result(held);
        consume();

        // Reset during the second RUN cycle aborts the operation.
        issue(16'hAAAA, 16'h5555, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("aborted_no_out_valid", out_valid, 0);
        end
        issue(16'h0F0F, 16'h00F1, 1'b0, 1);
        wait_result(held);
        check("post_reset_sum_const", held.sum, 16'h1000);
        consume();

        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
